// File: rtl/mux_pkg.sv
// mux_pkg: shared types and helpers for the arbitrated multiplexer.
//   arb_mode_t - arbitration policy selector (round-robin / fixed priority)
//   next_idx   - modular increment of a channel index, valid for any channel count
package mux_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_t;

  // (idx + 1) mod n without a divider; idx is always in [0, n-1]
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational request arbiter.
//   req       [NCH-1:0]  per-channel request
//   ptr       [SELW-1:0] round-robin starting point (ignored in fixed mode)
//   mode      1          0 = round-robin from ptr, 1 = lowest index wins
//   grant     [NCH-1:0]  one-hot grant (zero when no request)
//   grant_idx [SELW-1:0] encoded index of the granted channel
//   any_grant 1          some request was granted
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NCH = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  logic            mode,
  output logic [NCH-1:0]  grant,
  output logic [SELW-1:0] grant_idx,
  output logic            any_grant
);

  // Both searches run from the far end toward the preferred end so the last
  // hit (the highest-priority one) is the one that sticks.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    if (arb_mode_t'(mode) == ARB_FIXED) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (req[i]) begin
          grant_idx = SELW'(i);
          any_grant = 1'b1;
        end
      end
    end else begin
      for (int k = NCH - 1; k >= 0; k--) begin
        if (req[(int'(ptr) + k) % NCH]) begin
          grant_idx = SELW'((int'(ptr) + k) % NCH);
          any_grant = 1'b1;
        end
      end
    end
    if (any_grant) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/arb_mux_n.sv
// arb_mux_n: NCH-channel, WIDTH-bit registered mux with arbitration and
// valid/ready handshaking on both sides.
//   clk, reset_n          clock, synchronous active-low reset
//   mode                  0 = round-robin, 1 = fixed priority
//   in_valid/in_data      per-channel requests and words
//   in_ready              per-channel accept (one-hot or zero)
//   out_valid/out_data    one-entry output register
//   out_ch                channel that supplied out_data
//   out_ready             consumer accept
module arb_mux_n
  import mux_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int NCH = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       mode,
  input  logic [NCH-1:0]             in_valid,
  input  logic [NCH-1:0][WIDTH-1:0]  in_data,
  output logic [NCH-1:0]             in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [SELW-1:0]            out_ch,
  input  logic                       out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic [NCH-1:0]   grant;
  logic [SELW-1:0]  grant_idx;
  logic             any_grant;
  logic             load_en;
  logic             xfer;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .mode      (mode),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    // Register can take a word when empty or being drained this same cycle.
    load_en  = !out_valid_q || out_ready;
    xfer     = any_grant && load_en && reset_n;
    in_ready = (load_en && reset_n) ? grant : '0;

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[grant_idx];
      out_ch_d    = grant_idx;
      if (arb_mode_t'(mode) == ARB_RR) begin
        ptr_d = SELW'(next_idx(int'(grant_idx), NCH));
      end
    end else if (out_valid_q && out_ready) begin
      // Drain only: data and channel keep their last values.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// tb_arb_mux_n: bench for arb_mux_n with a 4-channel and a 3-channel instance
// sharing stimulus (the 3-channel one sees the low three channels).
module tb_arb_mux_n;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 mode;
  logic [3:0]           in_valid;
  logic [3:0][15:0]     in_data;
  logic                 out_ready;

  logic [3:0]           in_ready4;
  logic                 out_valid4;
  logic [15:0]          out_data4;
  logic [1:0]           out_ch4;

  logic [2:0]           in_ready3;
  logic                 out_valid3;
  logic [15:0]          out_data3;
  logic [1:0]           out_ch3;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  arb_mux_n #(.WIDTH(16), .NCH(4)) dut4 (
    .clk(clk), .reset_n(rst_n), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_data(out_data4), .out_ch(out_ch4),
    .out_ready(out_ready)
  );

  arb_mux_n #(.WIDTH(16), .NCH(3)) dut3 (
    .clk(clk), .reset_n(rst_n), .mode(mode),
    .in_valid(in_valid[2:0]), .in_data(in_data[2:0]), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
    .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: does the output hold a word, which word/channel, and where
  // the round-robin search starts.
  bit          m_v[2];
  logic [15:0] m_d[2];
  int          m_ch[2];
  int          m_ptr[2];

  function automatic int nch_of(input int u);
    return (u == 0) ? 4 : 3;
  endfunction

  // Which requester wins: fixed = lowest index, RR = first at/after ptr.
  function automatic int model_grant(input int n, input logic [3:0] v, input logic md, input int p);
    for (int k = 0; k < n; k++) begin
      if (v[md ? k : (p + k) % n]) return md ? k : (p + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(input int u);
    int g;
    g = model_grant(nch_of(u), in_valid, mode, m_ptr[u]);
    if (!rst_n || g < 0 || !(!m_v[u] || out_ready)) return 4'b0000;
    return 4'(1 << g);
  endfunction

  int mg;
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        m_v[u] = 1'b0; m_d[u] = '0; m_ch[u] = 0; m_ptr[u] = 0;
      end else begin
        mg = model_grant(nch_of(u), in_valid, mode, m_ptr[u]);
        if (mg >= 0 && (!m_v[u] || out_ready)) begin
          m_v[u]  = 1'b1;
          m_d[u]  = in_data[mg];
          m_ch[u] = mg;
          if (!mode) m_ptr[u] = (mg + 1) % nch_of(u);
          if (u == 0) $display("xfer n4 ch=%0d data=%h mode=%0d t=%0t", mg, in_data[mg], mode, $time);
        end else if (m_v[u] && out_ready) begin
          m_v[u] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("n4_out_valid", 32'(out_valid4), 32'(m_v[0]));
      chk("n4_in_ready",  32'(in_ready4),  32'(exp_ready(0)));
      if (m_v[0]) begin
        chk("n4_out_data", 32'(out_data4), 32'(m_d[0]));
        chk("n4_out_ch",   32'(out_ch4),   32'(m_ch[0]));
      end
      chk("n3_out_valid", 32'(out_valid3), 32'(m_v[1]));
      chk("n3_in_ready",  32'(in_ready3),  32'(exp_ready(1) & 4'b0111));
      if (m_v[1]) begin
        chk("n3_out_data", 32'(out_data3), 32'(m_d[1]));
        chk("n3_out_ch",   32'(out_ch3),   32'(m_ch[1]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_out4(input string name, input int ch);
    chk({name, "_valid"}, 32'(out_valid4), 32'd1);
    chk({name, "_ch"},    32'(out_ch4),    32'(ch));
    chk({name, "_data"},  32'(out_data4),  32'(16'h00A0 + ch));
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; out_ready = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) in_data[i] = 16'(16'h00A0 + i);
    step();
    chk_on = 1'b1;
    chk("rst_in_ready", 32'(in_ready4), 32'd0);
    step();
    chk("rst_valid", 32'(out_valid4), 32'd0);
    chk("rst_data",  32'(out_data4),  32'd0);
    chk("rst_ch",    32'(out_ch4),    32'd0);

    // Round-robin fairness with everyone requesting
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out4("rr", i % 4);
    end

    // Reset while holding a word, first grant restarts at channel 0
    rst_n = 1'b0;
    step();
    chk("midrst_valid", 32'(out_valid4), 32'd0);
    chk("midrst_data",  32'(out_data4),  32'd0);
    chk("midrst_ch",    32'(out_ch4),    32'd0);
    rst_n = 1'b1;
    step();
    chk_out4("after_rst", 0);

    // Fixed priority: channel 1 every time; ptr (now 1) must survive
    mode = 1'b1; in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out4("fixed", 1);
    end
    mode = 1'b0; in_valid = 4'b1111;
    step();
    chk_out4("ptr_kept", 1);

    // Backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out4("stall", 1);
      chk("stall_in_ready", 32'(in_ready4), 32'd0);
    end
    out_ready = 1'b1; in_valid = 4'b0100;
    #1;
    chk("release_in_ready", 32'(in_ready4), 32'b0100);
    step();
    chk_out4("release", 2);

    // Mode switch mid-stream
    in_valid = 4'b0010;
    step();
    chk_out4("sw_rr", 1);
    mode = 1'b1; in_valid = 4'b1101;
    step();
    chk_out4("sw_fixed", 0);
    mode = 1'b0;
    step();
    chk_out4("sw_back", 2);

    // Three-channel wrap
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; in_valid = 4'b0010;
    step();
    chk("n3_pre_ch", 32'(out_ch3), 32'd1);
    in_valid = 4'b0101;
    step();
    chk("n3_wrap_ch",   32'(out_ch3),   32'd2);
    chk("n3_wrap_data", 32'(out_data3), 32'h00A2);
    step();
    chk("n3_after_ch",   32'(out_ch3),   32'd0);
    chk("n3_after_data", 32'(out_data3), 32'h00A0);

    // Randomised traffic checked by the model every cycle
    for (int c = 0; c < 400; c++) begin
      step();
      in_valid  = 4'($urandom);
      for (int i = 0; i < 4; i++) in_data[i] = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      rst_n = ($urandom_range(0, 59) != 0);
    end
    step();
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
